// File: rtl/rr_bit_arbiter_if.sv
// rr_bit_arbiter_if: request/grant bundle between requesters and the round-robin arbiter
//   req/done      requester -> arbiter (request vector, owner release)
//   grant/grant_id/grant_valid/timeout  arbiter -> requesters
interface rr_bit_arbiter_if #(
  parameter int N   = 32,
  parameter int IDW = 6
);
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           timeout;
  modport master (output req, done, input grant, grant_id, grant_valid, timeout);
  modport slave  (input req, done, output grant, grant_id, grant_valid, timeout);
endinterface

// File: rtl/rr_bit_arbiter.sv
// rr_bit_arbiter: round-robin arbiter, one registered grant held until done (optional forced release under ARB_TIMEOUT_EN)
//   clk, reset  clock and synchronous active-high reset
//   bus         rr_bit_arbiter_if slave: req/done in, grant/grant_id/grant_valid/timeout out
module rr_bit_arbiter #(
  parameter int N        = 32,
  parameter int IDW      = 6,
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic reset,
  rr_bit_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, win;
  logic [N-1:0]   grant_q, grant_d;
  logic           tmo_q, tmo_d, hit, found;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // hold limit hits on the edge that would complete MAX_HOLD grant cycles
  assign cnt_d = (state_q == GRANT) ? cnt_q + CW'(1) : '0;
  assign hit   = (state_q == GRANT) && (cnt_q == CW'(MAX_HOLD - 1));
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_hold;
  assign unused_hold = (MAX_HOLD > 0);
  assign hit = 1'b0;
`endif
  // wrap-around first-set search: pass k<N accepts only idx>=ptr, pass k>=N accepts any idx
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!found && bus.req[k % N] && (k >= N || (k % N) >= int'(ptr_q))) begin
        win   = IDW'(k % N);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    grant_d = grant_q;
    tmo_d   = 1'b0;
    if (state_q == IDLE && found) begin
      state_d = GRANT;
      id_d    = win;
      grant_d = N'(1) << win;
    end else if (state_q == GRANT && (bus.done || hit)) begin
      state_d = IDLE;
      id_d    = IDW'(N);
      grant_d = '0;
      ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
      tmo_d   = !bus.done;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= IDW'(N);
      grant_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      tmo_q   <= tmo_d;
    end
  assign bus.grant       = grant_q;
  assign bus.grant_id    = id_q;
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.timeout     = tmo_q;
endmodule

// File: doc/rr_bit_arbiter.md
Name: rr_bit_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters.
- Core is a wrap-around find-first-set search over the request vector, starting at a rotating priority pointer.
- Issues one registered grant and holds it until the owner signals done.
- Sits between requester bit vectors (e.g. interrupt/event masks) and a single shared datapath.

Parameters:
N, 32, number of requesters
IDW, 6, width of grant_id; must hold values 0..N, where N encodes "no grant"
MAX_HOLD, 16, grant cycles before forced release; used only with ARB_TIMEOUT_EN

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  N  request vector; bit i = requester i wants the resource
done  input  1  owner finished; sampled only while grant_valid=1
grant  output  N  one-hot grant, registered
grant_id  output  IDW  index of granted requester; N when idle
grant_valid  output  1  a grant is active
timeout  output  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only)

Behaviour:
- Reset (clk edge with reset=1):
  - grant=0, grant_id=N, grant_valid=0, timeout=0.
  - ptr=0, state=IDLE, hold counter=0.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, winner = lowest set bit at index >= ptr. If none, winner = lowest set bit at index < ptr (wrap).
  - Next edge: grant=1<<winner, grant_id=winner, grant_valid=1, state->GRANT.
  - Latency is 1 cycle from req sample to grant.
  - If req==0, outputs hold their idle values.
  - done is ignored in IDLE.
- GRANT:
  - Grant outputs are frozen.
  - req is not re-examined; if the owner drops its req bit, the grant persists until done.
  - done=1 at an edge:
    - grant=0, grant_id=N, grant_valid=0.
    - ptr=(grant_id+1) mod N, i.e. ptr=0 when grant_id=N-1.
    - state->IDLE.
- Minimum spacing: one IDLE cycle between consecutive grants. A new grant appears 2 edges after the releasing done.
- Simultaneous requests: resolved purely by ptr order. No requester waits more than N-1 other grants.
- Internal winner logic is combinational: a loop over 2N positions with early exit, or equivalent masked/unmasked priority encode. grant_id is never driven to N while grant_valid=1.
- Reset mid-GRANT: takes priority over done and timeout; returns to reset values, ptr=0.
- ptr is IDW bits wide, always in 0..N-1.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle without done.
  - When the count reaches MAX_HOLD, the next edge force-releases exactly as done would (ptr advances past the owner) and pulses timeout=1 for one cycle.
  - done and the limit in the same cycle count as a normal release; timeout stays 0.
- Undefined:
  - No counter is built; timeout is tied to 0.
  - A grant persists indefinitely until done.
  - MAX_HOLD is unused.

Test Plan:
1. Reset, then req=32'h1000_1000 -> 1 cycle later grant_id=12, grant=32'h0000_1000. Pulse done -> grant_valid=0, ptr=13; next grant_id=28.
2. Wrap: after grant 28 released (ptr=29), req=32'h0000_0011 -> grant_id=0; after release (ptr=1) -> grant_id=4; after release (ptr=5) -> grant_id=0.
3. req=0 for 10 cycles, done toggling -> grant_valid=0, grant_id=32, grant=0 throughout, ptr unchanged.
4. Owner drops req: grant 3 active, req goes 0 -> grant_id stays 3 until done. Then req=32'h8000_0000 -> grant_id=31. Release -> ptr=0.
5. Reset asserted during GRANT with done=1 same cycle -> next edge all outputs at reset values. Then req=32'h1000_1010 -> grant_id=4 (ptr=0).
6. With ARB_TIMEOUT_EN, MAX_HOLD=16: grant 5, done held low -> forced release after 16 GRANT cycles, timeout=1 for exactly one cycle, ptr=6. Same test without the macro -> grant 5 held for 100 cycles, timeout=0.
